// File: rtl/tug_game_core.sv
// Tug of War game logic: button sync, press detection on slowenable,
// rope position FSM, win blink display and saturating win counters.
module tug_game_core #(
  parameter int NLED  = 7,
  parameter int BLINK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowenable,
  input  logic            btn_l,
  input  logic            btn_r,
  output logic [NLED-1:0] leds,
  output logic            win_l,
  output logic            win_r,
  output logic [3:0]      score_l,
  output logic [3:0]      score_r
);

  localparam int PW = $clog2(NLED);
  localparam int CW = (BLINK > 1) ? $clog2(BLINK) : 1;
  localparam logic [PW-1:0] CPOS = PW'((NLED - 1) / 2);
  localparam logic [PW-1:0] LPOS = PW'(NLED - 1);
  localparam logic [CW-1:0] CMAX = CW'(BLINK - 1);

  typedef enum logic [1:0] {PLAY, WIN_L, WIN_R} state_t;

  logic          s1_l, s1_r, sl, sr, last_l, last_r;
  logic          press_l, press_r;
  state_t        st, st_n;
  logic [PW-1:0] pos, pos_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          blink, blink_n;
  logic [3:0]    scl_n, scr_n;
  logic [NLED-1:0] leds_n;

  assign press_l = sl & ~last_l;
  assign press_r = sr & ~last_r;

  always_comb begin
    st_n    = st;
    pos_n   = pos;
    cnt_n   = cnt;
    blink_n = blink;
    scl_n   = score_l;
    scr_n   = score_r;
    if (slowenable) begin
      case (st)
        PLAY: begin
          if (press_l & ~press_r) begin
            pos_n = pos + 1'b1;
            if (pos_n == LPOS) begin
              st_n    = WIN_L;
              scl_n   = (score_l == 4'd15) ? score_l : score_l + 4'd1;
              cnt_n   = '0;
              blink_n = 1'b1;
            end
          end else if (press_r & ~press_l) begin
            pos_n = pos - 1'b1;
            if (pos_n == '0) begin
              st_n    = WIN_R;
              scr_n   = (score_r == 4'd15) ? score_r : score_r + 4'd1;
              cnt_n   = '0;
              blink_n = 1'b1;
            end
          end
        end
        default: begin
          // restart beats blink counting on the qualifying pulse
          if (sl & sr) begin
            st_n  = PLAY;
            pos_n = CPOS;
            cnt_n = '0;
          end else if (cnt == CMAX) begin
            cnt_n   = '0;
            blink_n = ~blink;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    leds_n = '0;
    case (st_n)
      PLAY:    leds_n = NLED'(1) << pos_n;
      WIN_L:   leds_n[NLED-1] = blink_n;
      WIN_R:   leds_n[0] = blink_n;
      default: leds_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_l    <= 1'b0;
      s1_r    <= 1'b0;
      sl      <= 1'b0;
      sr      <= 1'b0;
      last_l  <= 1'b0;
      last_r  <= 1'b0;
      st      <= PLAY;
      pos     <= CPOS;
      cnt     <= '0;
      blink   <= 1'b0;
      score_l <= 4'd0;
      score_r <= 4'd0;
      win_l   <= 1'b0;
      win_r   <= 1'b0;
      leds    <= NLED'(1) << CPOS;
    end else begin
      s1_l    <= btn_l;
      s1_r    <= btn_r;
      sl      <= s1_l;
      sr      <= s1_r;
      if (slowenable) begin
        last_l <= sl;
        last_r <= sr;
      end
      st      <= st_n;
      pos     <= pos_n;
      cnt     <= cnt_n;
      blink   <= blink_n;
      score_l <= scl_n;
      score_r <= scr_n;
      win_l   <= (st_n == WIN_L);
      win_r   <= (st_n == WIN_R);
      leds    <= leds_n;
    end
  end

endmodule

// File: doc/tug_game_core.md
# tug_game_core

Game-logic stage of the Tug of War design. Consumes the `slowenable` pulse from the 256:1 clock-enable divider and the two raw player pushbuttons. Tracks the rope position on a one-hot LED bar and detects a win. Drives the LED bar, the winner flags and per-player saturating win counters. Logic advances only on `slowenable` cycles, which gives inherent button debounce.

## Interface
- `NLED`, 7, LED count; odd, ≥3. Centre index `C = (NLED-1)/2`.
- `BLINK`, 4, number of `slowenable` pulses per half-period of the winner LED blink; ≥1.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `slowenable` in 1: one-`clk`-wide enable pulse from the divider, nominally every 256 clk.
- `btn_l` in 1: left player button, raw, asynchronous, active-high.
- `btn_r` in 1: right player button, raw, asynchronous, active-high.
- `leds` out NLED: rope display; `leds[NLED-1]` is the leftmost LED.
- `win_l` out 1: high while in WIN_L.
- `win_r` out 1: high while in WIN_R.
- `score_l` out 4: left wins, saturating at 15.
- `score_r` out 4: right wins, saturating at 15.

## Operation
- **Synchronizers.** Each button passes through a 2-flop synchronizer clocked every `clk`, giving `sl` and `sr`.
- **Sample registers.** `last_l` and `last_r` load `sl` and `sr` only on `slowenable` cycles.
- **Press detection.** `press_l = sl & ~last_l` and `press_r = sr & ~last_r`. Both are evaluated only when `slowenable=1`.
- **Position.** Register `pos`, range 0..NLED-1, `$clog2(NLED)` bits, no wrap. `leds = 1 << pos` in PLAY.
- **State machine.** States: PLAY, WIN_L, WIN_R.
  - PLAY, `press_l & ~press_r`: `pos+1`. If the new `pos` equals NLED-1, go to WIN_L and increment `score_l`.
  - PLAY, `press_r & ~press_l`: `pos-1`. If the new `pos` equals 0, go to WIN_R and increment `score_r`.
  - PLAY, simultaneous `press_l & press_r`: no move (cancel).
  - PLAY, holding a button: exactly one move per press, because no new edge occurs while held.
  - WIN_L / WIN_R: moves are ignored. Restart occurs on a `slowenable` cycle with `sl=1` and `sr=1`: go to PLAY with `pos=C` and clear the blink counter. Because `last_*` are now 1, the held restart buttons generate no presses.
- **Win display.**
  - In WIN_L, `leds` shows only bit NLED-1, ANDed with the `blink` phase.
  - In WIN_R, `leds` shows only bit 0, ANDed with `blink`.
  - The blink counter counts `slowenable` pulses 0..BLINK-1. `blink` toggles when the count wraps from BLINK-1 to 0.
  - `blink` is set to 1 on entry to WIN.
- **Scores.** Each score increments once per win and holds at 15. Scores are cleared only by `rst`.
- **`slowenable` low.** When `slowenable=0`, no state, position, sample, blink or score register changes; only the synchronizers run.

## Timing
- **Reset (`rst=0`, asynchronous).**
  - State PLAY, `pos=C`, `leds=1<<C` (0001000 for NLED=7).
  - `win_l=0`, `win_r=0`, `score_l=0`, `score_r=0`.
  - `last_l=0`, `last_r=0`, synchronizers 0, blink counter 0.
  - Reset is asynchronous. Asserting it mid-game or mid-blink returns the block to the reset values immediately; scores are lost.
- **Button latency.** A button edge is visible in `sl`/`sr` 2 clk later. It acts on the first `slowenable` pulse after that.
- **Output update.** `pos`, `leds`, the win flags and the scores are all registered. They update on the clock edge that ends the `slowenable` cycle, i.e. they are visible 1 clk after the pulse.
- **Short presses.** A press shorter than one `slowenable` period (about 256 clk) may be missed. This is by design.
- **Winning move.** `win_*` and `score_*` change on the same edge as the final `pos` update.
- **Restart.** Takes effect on the edge that ends the qualifying `slowenable` cycle.

## Test plan
- Release `rst`, run 1000 clk with no buttons → `leds=0001000`, `win_l=0`, `win_r=0`, scores 0.
- Three separate left press/release cycles, each spanning ≥2 `slowenable` pulses → `leds` steps 0010000, 0100000, 1000000. On the third step `win_l=1` and `score_l=1`.
- In WIN_L, run 16 `slowenable` pulses → `leds[6]` toggles every 4 pulses, other bits stay 0. Further right presses are ignored.
- Hold both buttons in WIN_L → PLAY with `leds=0001000` and `win_l=0`. Holding both for 5 more pulses causes no movement.
- Press both buttons rising on the same sample in PLAY → no move. Then hold left across 10 pulses → exactly one move, to 0010000.
- Apply 16 right wins → `score_r` saturates at 15. Assert `rst` mid-blink → immediate reset values.
